// File: rtl/hazard_pkg.sv
// -----------------------------------------------------------------------------
// hazard_pkg
// Shared types for the hazard control block of the 5-stage RV32I core.
//   REG_AW      register index width (32 architectural registers)
//   REG_X0      index of the hardwired-zero register
//   stage_t     shadow pipeline entry {v, rd, we, ld}
//   fwd_sel_t   EX operand source select
//   stage_match true when a shadow entry produces the value a source operand reads
// -----------------------------------------------------------------------------
package hazard_pkg;

  localparam int REG_AW = 5;
  localparam logic [REG_AW-1:0] REG_X0 = '0;

  typedef struct packed {
    logic              v;   // entry holds a real instruction (not a bubble)
    logic [REG_AW-1:0] rd;  // destination register
    logic              we;  // instruction writes rd
    logic              ld;  // instruction is a load
  } stage_t;

  typedef enum logic [1:0] {
    FWD_RF    = 2'b00,  // register file
    FWD_EXMEM = 2'b01,  // EX/MEM result
    FWD_MEMWB = 2'b10,  // MEM/WB result
    FWD_WB    = 2'b11   // WB write-through
  } fwd_sel_t;

  // x0 reads are never hazards: the register file returns zero for them.
  function automatic logic stage_match(input stage_t s, input logic [REG_AW-1:0] rs);
    return s.v & s.we & (s.rd == rs) & (rs != REG_X0);
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// -----------------------------------------------------------------------------
// hazard_ctrl_if
// Hazard flags link between DataPath (master) and hazard_ctrl (slave).
//   id_valid, curr_rd, id_rd_we, id_is_load, id_rs1, id_rs2   decode-stage info
//   ex_flush                                                   redirect kill of ID/EX
//   we_stall                                                   hold PC and IF/ID (comb)
//   we_bypass, fwd_rs1, fwd_rs2                                EX forward selects (reg)
// -----------------------------------------------------------------------------
interface hazard_ctrl_if;

  logic                          id_valid;
  logic [hazard_pkg::REG_AW-1:0] curr_rd;
  logic                          id_rd_we;
  logic                          id_is_load;
  logic [hazard_pkg::REG_AW-1:0] id_rs1;
  logic [hazard_pkg::REG_AW-1:0] id_rs2;
  logic                          ex_flush;
  logic                          we_stall;
  logic                          we_bypass;
  logic [1:0]                    fwd_rs1;
  logic [1:0]                    fwd_rs2;

  modport master (
    output id_valid, curr_rd, id_rd_we, id_is_load, id_rs1, id_rs2, ex_flush,
    input  we_stall, we_bypass, fwd_rs1, fwd_rs2
  );

  modport slave (
    input  id_valid, curr_rd, id_rd_we, id_is_load, id_rs1, id_rs2, ex_flush,
    output we_stall, we_bypass, fwd_rs1, fwd_rs2
  );

endinterface

// File: rtl/hazard_fwd_sel.sv
// -----------------------------------------------------------------------------
// hazard_fwd_sel
// Combinational forward-source priority select for one source operand.
//   i_ex_q, i_mem_q, i_wb_q  shadow pipeline entries (youngest first)
//   i_rs                     source register of the instruction in ID
//   o_sel                    nearest producer wins; FWD_RF when none matches
// -----------------------------------------------------------------------------
module hazard_fwd_sel
  import hazard_pkg::*;
(
  input  stage_t            i_ex_q,
  input  stage_t            i_mem_q,
  input  stage_t            i_wb_q,
  input  logic [REG_AW-1:0] i_rs,
  output fwd_sel_t          o_sel
);

  always_comb begin
    // NOTE: default assigned first so every path drives o_sel and no latch is inferred.
    o_sel = FWD_RF;
    if (stage_match(i_ex_q, i_rs))       o_sel = FWD_EXMEM;
    else if (stage_match(i_mem_q, i_rs)) o_sel = FWD_MEMWB;
    else if (stage_match(i_wb_q, i_rs))  o_sel = FWD_WB;
  end

endmodule

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
// Control-path end of the datapath hazard flags link. Tracks destination tags
// of the instructions in EX, MEM and WB to detect load-use stalls and to pick
// per-operand forward sources for the instruction entering EX.
//   clk         core clock
//   rst         asynchronous active-high reset
//   bus         hazard_ctrl_if.slave (decode info in, stall/forward out)
//   stall_cnt   cycles with we_stall=1, saturating   (HAZARD_STATS_EN only)
//   bypass_cnt  cycles with we_bypass=1, saturating  (HAZARD_STATS_EN only)
// Build option: define HAZARD_STATS_EN to add the statistics counters and the
// STAT_W parameter.
// -----------------------------------------------------------------------------
module hazard_ctrl
  import hazard_pkg::*;
`ifdef HAZARD_STATS_EN
#(
  parameter int STAT_W = 32
)
`endif
(
  input  logic              clk,
  input  logic              rst,
  hazard_ctrl_if.slave      bus
`ifdef HAZARD_STATS_EN
  ,
  output logic [STAT_W-1:0] stall_cnt,
  output logic [STAT_W-1:0] bypass_cnt
`endif
);

  stage_t   r_ex_q, r_mem_q, r_wb_q;
  fwd_sel_t r_fwd_rs1, r_fwd_rs2;

  stage_t   w_ex_next;
  fwd_sel_t w_sel_rs1, w_sel_rs2;
  logic     w_stall;
  logic     w_ex_bubble;

  // Load-use: the loaded value is not ready until the load reaches MEM/WB, so
  // a dependent instruction waits one cycle. A flush kills the dependent
  // anyway, so it overrides the stall.
  assign w_stall = bus.id_valid & r_ex_q.ld
                 & (stage_match(r_ex_q, bus.id_rs1) | stage_match(r_ex_q, bus.id_rs2))
                 & ~bus.ex_flush;

  assign w_ex_bubble = ~bus.id_valid | w_stall | bus.ex_flush;

  always_comb begin
    w_ex_next = '{v: bus.id_valid, rd: bus.curr_rd, we: bus.id_rd_we, ld: bus.id_is_load};
    if (w_ex_bubble) w_ex_next = '0;
  end

  hazard_fwd_sel u_fwd_rs1 (
    .i_ex_q  (r_ex_q),
    .i_mem_q (r_mem_q),
    .i_wb_q  (r_wb_q),
    .i_rs    (bus.id_rs1),
    .o_sel   (w_sel_rs1)
  );

  hazard_fwd_sel u_fwd_rs2 (
    .i_ex_q  (r_ex_q),
    .i_mem_q (r_mem_q),
    .i_wb_q  (r_wb_q),
    .i_rs    (bus.id_rs2),
    .o_sel   (w_sel_rs2)
  );

  // The selects are computed against the older instructions while the
  // consumer is in ID and registered alongside it, so they line up with ex_q.
  // MEM and WB always advance: a flush only kills instructions younger than
  // the redirect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ex_q    <= '0;
      r_mem_q   <= '0;
      r_wb_q    <= '0;
      r_fwd_rs1 <= FWD_RF;
      r_fwd_rs2 <= FWD_RF;
    end else begin
      // NOTE: non-blocking updates make the whole shadow pipeline shift on the
      // same edge regardless of statement order.
      r_ex_q    <= w_ex_next;
      r_mem_q   <= r_ex_q;
      r_wb_q    <= r_mem_q;
      r_fwd_rs1 <= w_ex_bubble ? FWD_RF : w_sel_rs1;
      r_fwd_rs2 <= w_ex_bubble ? FWD_RF : w_sel_rs2;
    end
  end

  assign bus.we_stall  = w_stall;
  assign bus.fwd_rs1   = r_fwd_rs1;
  assign bus.fwd_rs2   = r_fwd_rs2;
  assign bus.we_bypass = (r_fwd_rs1 != FWD_RF) | (r_fwd_rs2 != FWD_RF);

`ifdef HAZARD_STATS_EN
  logic [STAT_W-1:0] r_stall_cnt, r_bypass_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt  <= '0;
      r_bypass_cnt <= '0;
    end else begin
      if (w_stall && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + 1'b1;
      if (bus.we_bypass && (r_bypass_cnt != '1))
        r_bypass_cnt <= r_bypass_cnt + 1'b1;
    end
  end

  assign stall_cnt  = r_stall_cnt;
  assign bypass_cnt = r_bypass_cnt;
`endif

endmodule
